bcd_digit_packer: RTL and testbench

//   Collects BCD digits arriving one per handshake, most-significant digit first, into a packed

---
 rtl/bcd_digit_packer.sv | 97 +++++++++
 tb/tb_bcd_digit_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_packer.sv
// Packs MSD-first BCD digits into a right-aligned DIGITS-digit word and hands it downstream
// with a valid/ready handshake, flagging any word that contained a non-decimal nibble.
module bcd_digit_packer #(
    parameter int DIGITS = 4,
    parameter int W      = 4 * DIGITS,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dig_valid,
    input  logic [3:0]    dig_data,
    input  logic          dig_last,
    output logic          dig_ready,
    output logic          bcd_valid,
    output logic [W-1:0]  bcd_data,
    output logic          bcd_err,
    output logic [CW-1:0] bcd_ndig,
    input  logic          bcd_ready
);

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          err;

    logic          accept;
    logic          closing;
    logic          transfer;
    logic          digit_bad;
    logic [3:0]    digit;

    // Illegal nibbles are replaced by zero so the converter only ever sees decimal digits.
    always_comb begin
        digit_bad = (dig_data > 4'd9);
        digit     = digit_bad ? 4'h0 : dig_data;
        accept    = (state == COLLECT) && dig_valid;
        closing   = dig_last || (cnt == CW'(DIGITS - 1));
        transfer  = (state == OUTPUT) && bcd_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (accept && closing) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bcd_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // The error flag is sticky for the word being built and only drops on handoff or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (transfer) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (accept) begin
            acc <= {acc[W-5:0], digit};
            cnt <= cnt + 1'b1;
            if (digit_bad) begin
                err <= 1'b1;
            end
        end
    end

    assign dig_ready = (state == COLLECT);
    assign bcd_valid = (state == OUTPUT);
    assign bcd_data  = acc;
    assign bcd_err   = err;
    assign bcd_ndig  = cnt;

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Self-checking bench for bcd_digit_packer: table-driven words, hand-written multi-cycle
// sequences, and random digit streams scored against a queue-based word model.
module tb_bcd_digit_packer;

    localparam int DIGITS = 4;
    localparam int W      = 16;
    localparam int CW     = 3;

    logic          clk;
    logic          rst;
    logic          dig_valid;
    logic [3:0]    dig_data;
    logic          dig_last;
    logic          dig_ready;
    logic          bcd_valid;
    logic [W-1:0]  bcd_data;
    logic          bcd_err;
    logic [CW-1:0] bcd_ndig;
    logic          bcd_ready;

    int compared = 0;
    int failed   = 0;

    bcd_digit_packer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .dig_valid (dig_valid),
        .dig_data  (dig_data),
        .dig_last  (dig_last),
        .dig_ready (dig_ready),
        .bcd_valid (bcd_valid),
        .bcd_data  (bcd_data),
        .bcd_err   (bcd_err),
        .bcd_ndig  (bcd_ndig),
        .bcd_ready (bcd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
        logic [2:0]  ndig;
        logic [31:0] dec;
    } word_t;

    typedef struct packed {
        logic [2:0]  n;
        logic [15:0] digs;
        logic [15:0] expData;
        logic        expErr;
    } vec_t;

    word_t      expQ[$];
    logic [3:0] curD[$];
    bit         curErr = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word-level model: collect accepted digits and emit a finished word when the number ends.
    task automatic modelAccept(input logic [3:0] d, input logic last);
        word_t w;
        if (d > 4'd9) begin
            curErr = 1;
            curD.push_back(4'h0);
        end else begin
            curD.push_back(d);
        end
        if (last || curD.size() == DIGITS) begin
            w.data = '0;
            w.dec  = 0;
            foreach (curD[i]) begin
                w.data = w.data * 16 + 16'(curD[i]);
                w.dec  = w.dec * 10 + 32'(curD[i]);
            end
            w.err  = curErr;
            w.ndig = 3'(curD.size());
            expQ.push_back(w);
            curD.delete();
            curErr = 0;
        end
    endtask

    task automatic modelReset();
        curD.delete();
        curErr = 0;
        expQ.delete();
    endtask

    function automatic int bcdToBin(input logic [15:0] b);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            r = r * 10 + int'(b[4*i +: 4]);
        end
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the digit has been taken.
    task automatic applyStimulus(input logic [3:0] d, input logic last);
        int waitCycles = 0;
        bit taken = 0;
        dig_valid = 1'b1;
        dig_data  = d;
        dig_last  = last;
        while (!taken && waitCycles < 100) begin
            @(negedge clk);
            taken = dig_ready;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        dig_valid = 1'b0;
        dig_last  = 1'b0;
        dig_data  = 4'($urandom);
        if (taken) begin
            modelAccept(d, last);
        end else begin
            compared++;
            failed++;
            $display("[TB] FAIL digit_accept_timeout: got no dig_ready, expected dig_ready within 100 cycles");
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_dig_ready"}, 32'(dig_ready), 32'd1);
        checkOutput({tag, "_bcd_valid"}, 32'(bcd_valid), 32'd0);
        checkOutput({tag, "_bcd_data"},  32'(bcd_data),  32'd0);
        checkOutput({tag, "_bcd_err"},   32'(bcd_err),   32'd0);
        checkOutput({tag, "_bcd_ndig"},  32'(bcd_ndig),  32'd0);
    endtask

    // Scoreboard: every handshake transfer must match the next model word.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst && bcd_valid && bcd_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL sb_unexpected_word: got %0h, expected no word", bcd_data);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("sb_data", 32'(bcd_data), 32'(w.data));
                    checkOutput("sb_err",  32'(bcd_err),  32'(w.err));
                    checkOutput("sb_ndig", 32'(bcd_ndig), 32'(w.ndig));
                    checkOutput("sb_binary", 32'(bcdToBin(bcd_data)), w.dec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        bit stopReady = 0;

        vecs[0] = '{n: 3'd4, digs: 16'h1234, expData: 16'h1234, expErr: 1'b0};
        vecs[1] = '{n: 3'd2, digs: 16'h7500, expData: 16'h0075, expErr: 1'b0};
        vecs[2] = '{n: 3'd4, digs: 16'h9C31, expData: 16'h9031, expErr: 1'b1};
        vecs[3] = '{n: 3'd3, digs: 16'h5070, expData: 16'h0507, expErr: 1'b0};
        vecs[4] = '{n: 3'd1, digs: 16'h9000, expData: 16'h0009, expErr: 1'b0};
        vecs[5] = '{n: 3'd4, digs: 16'hFA09, expData: 16'h0009, expErr: 1'b1};
        vecs[6] = '{n: 3'd4, digs: 16'h9999, expData: 16'h9999, expErr: 1'b0};

        rst       = 1'b1;
        dig_valid = 1'b0;
        dig_data  = 4'h0;
        dig_last  = 1'b0;
        bcd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] table-driven words");
        bcd_ready = 1'b1;
        foreach (vecs[v]) begin
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                applyStimulus(vecs[v].digs[15-4*i -: 4],
                              (i == int'(vecs[v].n) - 1) && (vecs[v].n < 3'd4 || v % 2 == 0));
            end
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid", v), 32'(bcd_valid), 32'd1);
            checkOutput($sformatf("vec%0d_data", v),  32'(bcd_data),  32'(vecs[v].expData));
            checkOutput($sformatf("vec%0d_err", v),   32'(bcd_err),   32'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d_ndig", v),  32'(bcd_ndig),  32'(vecs[v].n));
            checkOutput($sformatf("vec%0d_dig_ready_low", v), 32'(dig_ready), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid_one_cycle", v), 32'(bcd_valid), 32'd0);
            checkOutput($sformatf("vec%0d_dig_ready_back", v),  32'(dig_ready), 32'd1);
            @(posedge clk);
            #1;
        end

        $display("[TB] downstream stall");
        bcd_ready = 1'b0;
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h4, 1'b0);
        applyStimulus(4'h6, 1'b0);
        applyStimulus(4'h8, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_valid", c),     32'(bcd_valid), 32'd1);
            checkOutput($sformatf("stall%0d_data", c),      32'(bcd_data),  32'h2468);
            checkOutput($sformatf("stall%0d_err", c),       32'(bcd_err),   32'd0);
            checkOutput($sformatf("stall%0d_dig_ready", c), 32'(dig_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bcd_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_xfer_valid",     32'(bcd_valid), 32'd1);
        checkOutput("stall_xfer_dig_ready", 32'(dig_ready), 32'd0);
        @(negedge clk);
        checkOutput("stall_after_dig_ready", 32'(dig_ready), 32'd1);
        checkOutput("stall_after_valid",     32'(bcd_valid), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] auto-close");
        applyStimulus(4'h1, 1'b0);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'h4, 1'b0);
        @(negedge clk);
        checkOutput("auto1_valid", 32'(bcd_valid), 32'd1);
        checkOutput("auto1_data",  32'(bcd_data),  32'h1234);
        checkOutput("auto1_ndig",  32'(bcd_ndig),  32'd4);
        @(posedge clk);
        #1;
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'h6, 1'b1);
        @(negedge clk);
        checkOutput("auto2_valid", 32'(bcd_valid), 32'd1);
        checkOutput("auto2_data",  32'(bcd_data),  32'h0056);
        checkOutput("auto2_ndig",  32'(bcd_ndig),  32'd2);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-word");
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'hC, 1'b0);
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        applyStimulus(4'h8, 1'b0);
        applyStimulus(4'h8, 1'b0);
        applyStimulus(4'h8, 1'b0);
        applyStimulus(4'h8, 1'b1);
        @(negedge clk);
        checkOutput("post_reset_data", 32'(bcd_data), 32'h8888);
        checkOutput("post_reset_ndig", 32'(bcd_ndig), 32'd4);
        checkOutput("post_reset_err",  32'(bcd_err),  32'd0);
        @(posedge clk);
        #1;

        $display("[TB] random streams");
        fork
            begin
                logic [3:0] d;
                for (int k = 0; k < 150; k++) begin
                    if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
                    else                           d = 4'($urandom_range(0, 9));
                    applyStimulus(d, $urandom_range(0, 4) == 0);
                end
                applyStimulus(4'($urandom_range(0, 9)), 1'b1);
                stopReady = 1;
            end
            begin
                while (!stopReady) begin
                    @(posedge clk);
                    #1;
                    bcd_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bcd_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
